// File: rtl/arm_mc_pkg.sv
// Shared state, ALU and mux encodings for the multicycle ARM control unit.
// ARM_MC_CMP_EN adds the CMP/TST function codes.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        FAULT    = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_t;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] FN_AND = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b0010;
    localparam logic [3:0] FN_ADD = 4'b0100;
    localparam logic [3:0] FN_ORR = 4'b1100;
`ifdef ARM_MC_CMP_EN
    localparam logic [3:0] FN_TST = 4'b1000;
    localparam logic [3:0] FN_CMP = 4'b1010;
`endif

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

endpackage

// File: rtl/arm_mc_flagcond.sv
// NZCV flag register with separate N/Z and C/V load enables, plus the
// combinational ARM condition-code check against the registered flags.
module arm_mc_flagcond
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       nz_we,
    input  logic       cv_we,
    output logic [3:0] flags,
    output logic       cond_ok
);

    logic n, z, c, v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= '0;
        end else begin
            if (nz_we) flags[3:2] <= alu_flags[3:2];
            if (cv_we) flags[1:0] <= alu_flags[1:0];
        end
    end

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            COND_EQ: cond_ok = z;
            COND_NE: cond_ok = !z;
            COND_CS: cond_ok = c;
            COND_CC: cond_ok = !c;
            COND_MI: cond_ok = n;
            COND_PL: cond_ok = !n;
            COND_VS: cond_ok = v;
            COND_VC: cond_ok = !v;
            COND_HI: cond_ok = c && !z;
            COND_LS: cond_ok = !c || z;
            COND_GE: cond_ok = (n == v);
            COND_LT: cond_ok = (n != v);
            COND_GT: cond_ok = !z && (n == v);
            COND_LE: cond_ok = z || (n != v);
            COND_AL: cond_ok = 1'b1;
            COND_NV: cond_ok = 1'b0;
            default: cond_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARMv4-subset control FSM with ready-handshake memory and watchdog.
// Define ARM_MC_CMP_EN to decode CMP/TST as flag-only operations.
module arm_mc_controller
    import arm_mc_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int TIMEOUT_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:12] instr,
    input  logic [3:0]  alu_flags,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_control,
    output logic [1:0]  imm_src,
    output logic [1:0]  reg_src,
    output logic [3:0]  flags,
    output logic        bus_error,
    output logic [3:0]  state
);

    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t               cur_state, next_state;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 wait_expired;
    logic                 cond_ok;
    logic                 nz_we, cv_we;
    logic                 mem_req_m, mem_write_m, ir_write_m, pc_write_m, reg_write_m;
    alu_ctrl_t            alu_op;
    logic [3:0]           funct;
    logic                 s_bit;
    logic                 rd_is_pc;
    logic                 unused_rn;

    assign funct        = instr[24:21];
    assign s_bit        = instr[20];
    assign rd_is_pc     = (instr[15:12] == 4'b1111);
    assign unused_rn    = ^instr[19:16];
    assign wait_expired = (wait_cnt == WAIT_LAST);

    arm_mc_flagcond u_flagcond (
        .clk       (clk),
        .reset     (reset),
        .cond      (instr[31:28]),
        .alu_flags (alu_flags),
        .nz_we     (nz_we),
        .cv_we     (cv_we),
        .flags     (flags),
        .cond_ok   (cond_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur_state <= FETCH;
        else       cur_state <= next_state;
    end

    // Counts stalled request cycles; any state change restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          wait_cnt <= '0;
        else if (next_state != cur_state)   wait_cnt <= '0;
        else if (mem_req_m && !mem_ready)   wait_cnt <= wait_cnt + 1'b1;
    end

    always_comb begin
        next_state  = cur_state;
        mem_req_m   = 1'b0;
        mem_write_m = 1'b0;
        ir_write_m  = 1'b0;
        pc_write_m  = 1'b0;
        reg_write_m = 1'b0;
        adr_src     = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RM;
        alu_op      = ALU_ADD;
        imm_src     = IMM_8;
        reg_src     = 2'b00;
        nz_we       = 1'b0;
        cv_we       = 1'b0;
        bus_error   = 1'b0;
        case (cur_state)
            FETCH: begin
                mem_req_m  = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (mem_ready) begin
                    ir_write_m = 1'b1;
                    pc_write_m = 1'b1;
                    next_state = DECODE;
                end else if (wait_expired) begin
                    next_state = FAULT;
                end
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (!cond_ok) begin
                    next_state = FETCH;
                end else begin
                    case (instr[27:26])
                        OP_DP:   next_state = instr[25] ? EXECUTEI : EXECUTER;
                        OP_MEM:  next_state = MEMADR;
                        OP_BR:   next_state = BRANCH;
                        default: next_state = FAULT;
                    endcase
                end
            end
            MEMADR: begin
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_12;
                next_state = s_bit ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req_m = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready)         next_state = MEMWB;
                else if (wait_expired) next_state = FAULT;
            end
            MEMWB: begin
                result_src  = RES_DATA;
                reg_write_m = 1'b1;
                pc_write_m  = rd_is_pc;
                next_state  = FETCH;
            end
            MEMWRITE: begin
                mem_req_m   = 1'b1;
                mem_write_m = 1'b1;
                adr_src     = 1'b1;
                reg_src     = 2'b10;
                if (mem_ready)         next_state = FETCH;
                else if (wait_expired) next_state = FAULT;
            end
            // Flag writes happen here so ALUWB sees a stable ALUOut register.
            EXECUTER, EXECUTEI: begin
                alu_src_b  = (cur_state == EXECUTEI) ? SRCB_IMM : SRCB_RM;
                next_state = ALUWB;
                case (funct)
                    FN_ADD: begin alu_op = ALU_ADD; nz_we = s_bit; cv_we = s_bit; end
                    FN_SUB: begin alu_op = ALU_SUB; nz_we = s_bit; cv_we = s_bit; end
                    FN_AND: begin alu_op = ALU_AND; nz_we = s_bit; end
                    FN_ORR: begin alu_op = ALU_ORR; nz_we = s_bit; end
`ifdef ARM_MC_CMP_EN
                    FN_CMP: begin
                        alu_op     = ALU_SUB;
                        nz_we      = 1'b1;
                        cv_we      = 1'b1;
                        next_state = FETCH;
                    end
                    FN_TST: begin
                        alu_op     = ALU_AND;
                        nz_we      = 1'b1;
                        next_state = FETCH;
                    end
`endif
                    default: next_state = FAULT;
                endcase
            end
            ALUWB: begin
                reg_write_m = 1'b1;
                pc_write_m  = rd_is_pc;
                next_state  = FETCH;
            end
            BRANCH: begin
                reg_src    = 2'b01;
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_24;
                result_src = RES_ALURESULT;
                pc_write_m = 1'b1;
                next_state = FETCH;
            end
            FAULT: begin
                bus_error  = 1'b1;
                next_state = FAULT;
            end
            default: next_state = FAULT;
        endcase
    end

    // Reset must kill any in-flight request so a pending store never commits.
    assign mem_req     = mem_req_m   & ~reset;
    assign mem_write   = mem_write_m & ~reset;
    assign ir_write    = ir_write_m  & ~reset;
    assign pc_write    = pc_write_m  & ~reset;
    assign reg_write   = reg_write_m & ~reset;
    assign alu_control = alu_op;
    assign state       = cur_state;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed, table-driven bench for arm_mc_controller plus hand-written
// sequences for memory stalls, watchdog fault, reset mid-store and CMP.
`timescale 1ns/1ps
module tb_arm_mc_controller;
    import arm_mc_pkg::*;

    localparam logic [19:0] I_ADD   = 20'hE2802;
    localparam logic [19:0] I_SUBS  = 20'hE0503;
    localparam logic [19:0] I_ADDEQ = 20'h02844;
    localparam logic [19:0] I_ADDNE = 20'h12844;
    localparam logic [19:0] I_NV    = 20'hF2802;
    localparam logic [19:0] I_B     = 20'hEAFFF;
    localparam logic [19:0] I_ADDPC = 20'hE280F;
    localparam logic [19:0] I_STR   = 20'hE5815;
    localparam logic [19:0] I_LDR   = 20'hE5915;
    localparam logic [19:0] I_ANDS  = 20'hE0100;
    localparam logic [19:0] I_CMP   = 20'hE1510;

    // {mem_req, mem_write, ir_write, pc_write, reg_write}
    localparam logic [4:0] E_NONE  = 5'b00000;
    localparam logic [4:0] E_FETCH = 5'b10110;
    localparam logic [4:0] E_WB    = 5'b00001;
    localparam logic [4:0] E_WBPC  = 5'b00011;
    localparam logic [4:0] E_BR    = 5'b00010;
    localparam logic [4:0] E_RD    = 5'b10000;
    localparam logic [4:0] E_WR    = 5'b11000;

    // {adr_src, reg_src, alu_src_a, alu_src_b, imm_src, alu_control, result_src}
    localparam logic [11:0] M_FD   = 12'b0_00_1_10_00_00_10;
    localparam logic [11:0] M_EXI  = 12'b0_00_0_01_00_00_00;
    localparam logic [11:0] M_SUB  = 12'b0_00_0_00_00_01_00;
    localparam logic [11:0] M_AND  = 12'b0_00_0_00_00_10_00;
    localparam logic [11:0] M_WB   = 12'b0_00_0_00_00_00_00;
    localparam logic [11:0] M_MADR = 12'b0_00_0_01_01_00_00;
    localparam logic [11:0] M_MRD  = 12'b1_00_0_00_00_00_00;
    localparam logic [11:0] M_MWB  = 12'b0_00_0_00_00_00_01;
    localparam logic [11:0] M_MWR  = 12'b1_10_0_00_00_00_00;
    localparam logic [11:0] M_BR   = 12'b0_01_0_01_10_00_10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] instr = '0;
    logic [3:0]  alu_flags = '0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  result_src, alu_src_b, alu_control, imm_src, reg_src;
    logic        alu_src_a, bus_error;
    logic [3:0]  flags, state;

    typedef struct {
        logic [19:0] instr;
        logic [3:0]  alu_flags;
        logic        ready;
        state_t      st;
        logic [4:0]  en;
        logic [3:0]  flags;
        logic [11:0] mux;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   fails  = 0;

    arm_mc_controller #(.TIMEOUT(4), .TIMEOUT_W(3)) dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_flags(alu_flags),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
        .reg_src(reg_src), .flags(flags), .bus_error(bus_error), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [4:0] en_now();
        return {mem_req, mem_write, ir_write, pc_write, reg_write};
    endfunction

    function automatic logic [11:0] mux_now();
        return {adr_src, reg_src, alu_src_a, alu_src_b, imm_src, alu_control, result_src};
    endfunction

    function automatic void add(input logic [19:0] i, input logic [3:0] af, input state_t st,
                                input logic [4:0] en, input logic [3:0] fl, input logic [11:0] mx);
        vec_t v;
        v.instr = i; v.alu_flags = af; v.ready = 1'b1;
        v.st = st; v.en = en; v.flags = fl; v.mux = mx;
        vecs.push_back(v);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic apply_stimulus(input logic [19:0] i, input logic [3:0] af, input logic rdy);
        @(negedge clk);
        reset = 1'b0; instr = i; alu_flags = af; mem_ready = rdy;
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0; alu_flags = 4'h0;
        #1;
        check_output("reset_state", 32'(state), 32'(FETCH));
        check_output("reset_enables", 32'(en_now()), 32'(E_NONE));
        check_output("reset_flags", 32'(flags), 32'h0);
        check_output("reset_bus_error", 32'(bus_error), 32'h0);
    endtask

    task automatic check_state(input string name, input state_t exp);
        check_output(name, 32'(state), 32'(exp));
    endtask

    initial begin
        add(I_ADD,   4'h0, FETCH,    E_FETCH, 4'h0, M_FD);
        add(I_ADD,   4'h0, DECODE,   E_NONE,  4'h0, M_FD);
        add(I_ADD,   4'h0, EXECUTEI, E_NONE,  4'h0, M_EXI);
        add(I_ADD,   4'h0, ALUWB,    E_WB,    4'h0, M_WB);
        add(I_SUBS,  4'h6, FETCH,    E_FETCH, 4'h0, M_FD);
        add(I_SUBS,  4'h6, DECODE,   E_NONE,  4'h0, M_FD);
        add(I_SUBS,  4'h6, EXECUTER, E_NONE,  4'h0, M_SUB);
        add(I_SUBS,  4'h6, ALUWB,    E_WB,    4'h6, M_WB);
        add(I_ADDEQ, 4'hF, FETCH,    E_FETCH, 4'h6, M_FD);
        add(I_ADDEQ, 4'hF, DECODE,   E_NONE,  4'h6, M_FD);
        add(I_ADDEQ, 4'hF, EXECUTEI, E_NONE,  4'h6, M_EXI);
        add(I_ADDEQ, 4'hF, ALUWB,    E_WB,    4'h6, M_WB);
        add(I_ADDNE, 4'hF, FETCH,    E_FETCH, 4'h6, M_FD);
        add(I_ADDNE, 4'hF, DECODE,   E_NONE,  4'h6, M_FD);
        add(I_NV,    4'hF, FETCH,    E_FETCH, 4'h6, M_FD);
        add(I_NV,    4'hF, DECODE,   E_NONE,  4'h6, M_FD);
        add(I_B,     4'hF, FETCH,    E_FETCH, 4'h6, M_FD);
        add(I_B,     4'hF, DECODE,   E_NONE,  4'h6, M_FD);
        add(I_B,     4'hF, BRANCH,   E_BR,    4'h6, M_BR);
        add(I_ADDPC, 4'h0, FETCH,    E_FETCH, 4'h6, M_FD);
        add(I_ADDPC, 4'h0, DECODE,   E_NONE,  4'h6, M_FD);
        add(I_ADDPC, 4'h0, EXECUTEI, E_NONE,  4'h6, M_EXI);
        add(I_ADDPC, 4'h0, ALUWB,    E_WBPC,  4'h6, M_WB);
        add(I_STR,   4'h0, FETCH,    E_FETCH, 4'h6, M_FD);
        add(I_STR,   4'h0, DECODE,   E_NONE,  4'h6, M_FD);
        add(I_STR,   4'h0, MEMADR,   E_NONE,  4'h6, M_MADR);
        add(I_STR,   4'h0, MEMWRITE, E_WR,    4'h6, M_MWR);
        add(I_LDR,   4'h0, FETCH,    E_FETCH, 4'h6, M_FD);
        add(I_LDR,   4'h0, DECODE,   E_NONE,  4'h6, M_FD);
        add(I_LDR,   4'h0, MEMADR,   E_NONE,  4'h6, M_MADR);
        add(I_LDR,   4'h0, MEMREAD,  E_RD,    4'h6, M_MRD);
        add(I_LDR,   4'h0, MEMWB,    E_WB,    4'h6, M_MWB);
        add(I_ANDS,  4'hF, FETCH,    E_FETCH, 4'h6, M_FD);
        add(I_ANDS,  4'hF, DECODE,   E_NONE,  4'h6, M_FD);
        add(I_ANDS,  4'hF, EXECUTER, E_NONE,  4'h6, M_AND);
        add(I_ANDS,  4'hF, ALUWB,    E_WB,    4'hE, M_WB);

        reset_dut();
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].instr, vecs[i].alu_flags, vecs[i].ready);
            check_output($sformatf("row%0d_state", i), 32'(state), 32'(vecs[i].st));
            check_output($sformatf("row%0d_enables", i), 32'(en_now()), 32'(vecs[i].en));
            check_output($sformatf("row%0d_flags", i), 32'(flags), 32'(vecs[i].flags));
            check_output($sformatf("row%0d_muxes", i), 32'(mux_now()), 32'(vecs[i].mux));
        end

        // LDR with three stall cycles in both FETCH and MEMREAD: 11 cycles total.
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(I_LDR, 4'h0, 1'b0);
            check_state($sformatf("ldr_fetch_wait%0d_state", k), FETCH);
            check_output($sformatf("ldr_fetch_wait%0d_enables", k), 32'(en_now()), 32'(E_RD));
        end
        apply_stimulus(I_LDR, 4'h0, 1'b1);
        check_output("ldr_fetch_done_enables", 32'(en_now()), 32'(E_FETCH));
        apply_stimulus(I_LDR, 4'h0, 1'b0);
        check_state("ldr_decode_state", DECODE);
        apply_stimulus(I_LDR, 4'h0, 1'b0);
        check_state("ldr_memadr_state", MEMADR);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(I_LDR, 4'h0, 1'b0);
            check_state($sformatf("ldr_read_wait%0d_state", k), MEMREAD);
            check_output($sformatf("ldr_read_wait%0d_muxes", k), 32'(mux_now()), 32'(M_MRD));
            check_output($sformatf("ldr_read_wait%0d_req", k), 32'(mem_req), 32'h1);
        end
        apply_stimulus(I_LDR, 4'h0, 1'b1);
        check_state("ldr_read_done_state", MEMREAD);
        apply_stimulus(I_LDR, 4'h0, 1'b0);
        check_state("ldr_memwb_state", MEMWB);
        check_output("ldr_memwb_enables", 32'(en_now()), 32'(E_WB));
        check_output("ldr_memwb_result_src", 32'(result_src), 32'(RES_DATA));
        apply_stimulus(I_LDR, 4'h0, 1'b0);
        check_state("ldr_total_cycles", FETCH);

        // STR whose memory never answers: faults after exactly 4 wait cycles.
        reset_dut();
        apply_stimulus(I_STR, 4'h0, 1'b1);
        apply_stimulus(I_STR, 4'h0, 1'b0);
        apply_stimulus(I_STR, 4'h0, 1'b0);
        check_state("str_memadr_state", MEMADR);
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(I_STR, 4'h0, 1'b0);
            check_state($sformatf("str_wait%0d_state", k), MEMWRITE);
            check_output($sformatf("str_wait%0d_enables", k), 32'(en_now()), 32'(E_WR));
        end
        apply_stimulus(I_STR, 4'h0, 1'b0);
        check_state("str_timeout_state", FAULT);
        check_output("str_timeout_bus_error", 32'(bus_error), 32'h1);
        check_output("str_timeout_enables", 32'(en_now()), 32'(E_NONE));
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(I_STR, 4'hF, 1'b1);
            check_state($sformatf("fault_sticky%0d_state", k), FAULT);
            check_output($sformatf("fault_sticky%0d_bus_error", k), 32'(bus_error), 32'h1);
            check_output($sformatf("fault_sticky%0d_enables", k), 32'(en_now()), 32'(E_NONE));
        end
        reset_dut();

        // Reset arriving in the middle of a stalled store drops the request at once.
        apply_stimulus(I_STR, 4'h0, 1'b1);
        apply_stimulus(I_STR, 4'h0, 1'b0);
        apply_stimulus(I_STR, 4'h0, 1'b0);
        apply_stimulus(I_STR, 4'h0, 1'b0);
        check_output("midstore_write_before", 32'(mem_write), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_output("midstore_reset_enables", 32'(en_now()), 32'(E_NONE));
        check_state("midstore_reset_state", FETCH);

        // CMP R1,R1: flag-only compare when enabled, illegal otherwise.
        reset_dut();
        apply_stimulus(I_CMP, 4'h6, 1'b1);
        apply_stimulus(I_CMP, 4'h6, 1'b1);
        apply_stimulus(I_CMP, 4'h6, 1'b1);
        check_state("cmp_execute_state", EXECUTER);
        check_output("cmp_execute_reg_write", 32'(reg_write), 32'h0);
        apply_stimulus(I_CMP, 4'h0, 1'b1);
`ifdef ARM_MC_CMP_EN
        check_state("cmp_next_state", FETCH);
        check_output("cmp_flags", 32'(flags), 32'h6);
        check_output("cmp_reg_write", 32'(reg_write), 32'h0);
`else
        check_state("cmp_next_state", FAULT);
        check_output("cmp_flags", 32'(flags), 32'h0);
        check_output("cmp_bus_error", 32'(bus_error), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
- Control unit for the multicycle ARMv4-subset core. It replaces the single-cycle combinational controller.
- Sequences each instruction through FETCH/DECODE/EXECUTE/WRITEBACK states over one shared instruction/data memory.
- Memory is accessed through a ready-based handshake with variable latency and a watchdog timeout.
- Holds the NZCV flag register. The condition check is done once, in DECODE. An instruction whose condition fails retires with no architectural writes.

Parameters:
- TIMEOUT, 16, maximum cycles to wait for mem_ready before faulting; legal range 1..2^TIMEOUT_W-1.
- TIMEOUT_W, 5, width of the wait counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- instr  in  20  instr[31:12] from the instruction register
- alu_flags  in  4  {N,Z,C,V} from the ALU
- mem_ready  in  1  memory has completed the current access this cycle
- mem_req  out  1  memory access request; held high until mem_ready
- mem_write  out  1  qualifies mem_req as a store
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  load the instruction register
- pc_write  out  1  load the PC
- reg_write  out  1  register file write enable
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  1  0 = Rn, 1 = PC
- alu_src_b  out  2  00 = Rm, 01 = ExtImm, 10 = constant 4
- alu_control  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- imm_src  out  2  00 imm8, 01 imm12, 10 branch imm24
- reg_src  out  2  {Rd-as-RA2 for STR, R15-as-RA1 for B}
- flags  out  4  current NZCV register
- bus_error  out  1  sticky fault indication
- state  out  4  current FSM state (debug)

Behaviour:
- Reset (asynchronous):
  - state = FETCH, flags = 0, wait counter = 0, bus_error = 0.
  - All write enables and mem_req are 0 while reset is high. The first cycle after release is FETCH.
- Outputs are Moore outputs of the state. The only exceptions are pc_write, ir_write, reg_write in MEMWB, and the transition out of memory states, which are gated by mem_ready and by cond_ok where stated.
- FETCH:
  - Drives mem_req=1, adr_src=0, alu_src_a=1, alu_src_b=10, ADD, result_src=10.
  - ir_write and pc_write pulse only in the cycle where mem_ready=1; the FSM then moves to DECODE.
- DECODE:
  - Drives alu_src_a=1, alu_src_b=10, ADD, result_src=10, so R15 reads return PC+8.
  - Evaluates cond_ok from instr[31:28] against flags, using the standard 15-code ARM table. Code 1111 is treated as false.
  - If !cond_ok: return to FETCH.
  - Else, by instr[27:26]:
    - 00 goes to EXECUTEI if instr[25]=1, otherwise EXECUTER.
    - 01 goes to MEMADR.
    - 10 goes to BRANCH.
    - 11 goes to FAULT.
- MEMADR: alu_src_a=0, alu_src_b=01, imm_src=01, ADD. Next state is MEMREAD if L=instr[20]=1, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Waits for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1. If Rd=1111, pc_write=1. Next state FETCH.
- MEMWRITE:
  - mem_req=1, mem_write=1, adr_src=1, reg_src[1]=1.
  - Waits for mem_ready, then FETCH.
  - The store is committed by memory only on the mem_ready cycle.
- EXECUTER / EXECUTEI:
  - ALU sources 0/00 (EXECUTER) or 0/01 (EXECUTEI), imm_src=00.
  - alu_control decoded from instr[24:21]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR. Any other value goes to FAULT.
  - If S=instr[20]: flags[3:2] are loaded at the end of the cycle. flags[1:0] are loaded only for ADD/SUB.
  - Next state ALUWB.
- ALUWB: result_src=00, reg_write=1. If Rd=1111, pc_write=1. Next state FETCH.
- BRANCH: alu_src_a=0, reg_src[0]=1, alu_src_b=01, imm_src=10, ADD, result_src=10, pc_write=1. Next state FETCH.
- Wait counter:
  - Clears on every state change. Increments each cycle mem_req=1 && !mem_ready.
  - When the counter reaches TIMEOUT without mem_ready, go to FAULT. An access therefore faults after exactly TIMEOUT wait cycles.
  - If mem_ready arrives on the same cycle the limit is reached, mem_ready wins.
- FAULT: absorbing state. bus_error=1, all enables and mem_req are 0. Only reset exits.
- Latencies with zero-wait memory (mem_ready tied high):
  - data-processing: 4 cycles
  - LDR: 5 cycles
  - STR: 4 cycles
  - B: 3 cycles
  - condition-failed instruction: 2 cycles
- Reset asserted mid-access: drops mem_req immediately. A pending store must not commit.

Optional Feature:
- ARM_MC_CMP_EN
- Defined:
  - Funct 1010 (CMP) decodes to SUB and 1000 (TST) decodes to AND.
  - Both force a flag update regardless of S. CMP writes all four flags; TST writes N and Z only.
  - Both skip ALUWB and return straight to FETCH; reg_write is never asserted.
- Undefined: both encodings go to FAULT.

Decomposition:
- Package arm_mc_pkg holds:
  - state_t enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, FAULT.
  - alu_ctrl_t codes.
  - cond code constants, op constants (OP_DP=00, OP_MEM=01, OP_BR=10).
  - result_src and alu_src_b encodings.
- Sub-module arm_mc_flagcond: holds the flag register with split N/Z vs C/V enables and the combinational cond_ok table.

Test Plan:
- ADD R2,R0,#5 with R0=3 and mem_ready tied high → states FETCH, DECODE, EXECUTEI, ALUWB; reg_write pulses once, in cycle 4; pc_write pulses in FETCH only.
- SUBS producing zero, then ADDEQ → Z=1 is latched; ADDEQ executes. Then ADDNE → 2-cycle retire, no reg_write.
- LDR with mem_ready delayed 3 cycles in both FETCH and MEMREAD → mem_req held steady the whole time; total 11 cycles; reg_write in MEMWB with result_src=01.
- STR with TIMEOUT=4 and mem_ready never asserted in MEMWRITE → FAULT after exactly 4 wait cycles; bus_error=1 and sticky; mem_write drops; reset clears everything.
- B to -2 words (imm24=0xFFFFFE) → BRANCH state with imm_src=10 and pc_write=1; 3-cycle instruction; flags unchanged.
- With ARM_MC_CMP_EN: CMP R1,R1 → flags=0110 and no reg_write. Without the macro, the same encoding → FAULT.
